// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and requester IDs for the memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between CPU and debug requests.
// MEM_ARB_DBG_PRIORITY_EN selects fixed debug priority instead of round-robin.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last,
    output logic any,
    output logic win
);
    assign any = cpu_req | dbg_req;
`ifdef MEM_ARB_DBG_PRIORITY_EN
    logic unused_last;
    assign unused_last = last;
    assign win = dbg_req ? REQ_DBG : REQ_CPU;
`else
    // On a tie the side that did not win last time gets the grant
    assign win = (cpu_req && dbg_req) ? ~last : (dbg_req ? REQ_DBG : REQ_CPU);
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: req/ack arbiter sharing one synchronous RAM between CPU and debug port.
// Define MEM_ARB_DBG_PRIORITY_EN for fixed debug priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [15:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_din,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_dout,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              owner,
    output logic              busy
);
    state_t state, state_n;
    logic any, win, acc_we, acc_we_n, owner_n, ram_we_n, cpu_ack_n, dbg_ack_n, busy_n;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [DATA_W-1:0] ram_din_n, cpu_dout_n, dbg_dout_n;

    mem_arb_pick u_pick (
        .cpu_req (cpu_req),
        .dbg_req (dbg_req),
        .last    (owner),
        .any     (any),
        .win     (win)
    );

    generate
        if (ADDR_W < 16) begin : g_trunc
            logic unused_addr_hi;
            assign unused_addr_hi = ^{cpu_addr[15:ADDR_W], dbg_addr[15:ADDR_W]};
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= REQ_DBG;
            acc_we   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            cpu_ack  <= 1'b0;
            dbg_ack  <= 1'b0;
            cpu_dout <= '0;
            dbg_dout <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            acc_we   <= acc_we_n;
            ram_we   <= ram_we_n;
            ram_addr <= ram_addr_n;
            ram_din  <= ram_din_n;
            cpu_ack  <= cpu_ack_n;
            dbg_ack  <= dbg_ack_n;
            cpu_dout <= cpu_dout_n;
            dbg_dout <= dbg_dout_n;
            busy     <= busy_n;
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        acc_we_n   = acc_we;
        ram_we_n   = 1'b0;
        ram_addr_n = ram_addr;
        ram_din_n  = ram_din;
        cpu_ack_n  = 1'b0;
        dbg_ack_n  = 1'b0;
        cpu_dout_n = cpu_dout;
        dbg_dout_n = dbg_dout;
        case (state)
            IDLE: if (any) begin
                state_n    = ACC;
                owner_n    = win;
                ram_we_n   = win ? dbg_we : cpu_we;
                acc_we_n   = ram_we_n;
                ram_addr_n = win ? dbg_addr[ADDR_W-1:0] : cpu_addr[ADDR_W-1:0];
                ram_din_n  = win ? dbg_din : cpu_din;
            end
            ACC: begin
                state_n   = DONE;
                cpu_ack_n = owner == REQ_CPU;
                dbg_ack_n = owner == REQ_DBG;
            end
            DONE: begin
                // RAM read data is valid now; capture it for the owner on the way out
                state_n    = IDLE;
                cpu_dout_n = (!acc_we && owner == REQ_CPU) ? ram_dout : cpu_dout;
                dbg_dout_n = (!acc_we && owner == REQ_DBG) ? ram_dout : dbg_dout;
            end
            default: state_n = IDLE;
        endcase
        busy_n = state_n != IDLE;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a transaction-timeline reference model.
// Honours MEM_ARB_DBG_PRIORITY_EN for the expected grant order.
module tb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
    } op_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] cpu_addr = '0, dbg_addr = '0;
    logic [DW-1:0] cpu_din = '0, dbg_din = '0;
    logic cpu_ack, dbg_ack, ram_we, owner, busy;
    logic [DW-1:0] cpu_dout, dbg_dout, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
        .dbg_ack(dbg_ack), .dbg_dout(dbg_dout),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .owner(owner), .busy(busy)
    );

    // Synchronous RAM outside the arbiter, as in the lab top level
    logic [DW-1:0] ram [256];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    int vec = 0, err = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vec++;
        if (a !== e) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: each grant is an event at cycle g; outputs follow as offsets from g
    int cyc = 0, g = 0;
    logic act = 1'b0, g_we = 1'b0, m_owner = 1'b1, w;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din = '0, m_cdout = '0, m_ddout = '0, rd = '0;
    logic [DW-1:0] mem_m [256];

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                act = 1'b0; m_owner = 1'b1; m_addr = '0; m_din = '0;
                m_cdout = '0; m_ddout = '0; cyc = 0;
            end else begin
                cyc++;
                if (!act) begin
                    if (cpu_req || dbg_req) begin
`ifdef MEM_ARB_DBG_PRIORITY_EN
                        w = dbg_req;
`else
                        w = (cpu_req && dbg_req) ? !m_owner : dbg_req;
`endif
                        act = 1'b1; g = cyc; m_owner = w;
                        g_we = w ? dbg_we : cpu_we;
                        m_addr = w ? dbg_addr[AW-1:0] : cpu_addr[AW-1:0];
                        m_din = w ? dbg_din : cpu_din;
                    end
                end else if (cyc == g + 1) begin
                    if (g_we) mem_m[m_addr] = m_din;
                    else rd = mem_m[m_addr];
                end else begin
                    act = 1'b0;
                    if (!g_we) begin
                        if (m_owner) m_ddout = rd;
                        else m_cdout = rd;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", busy, act);
            chk("owner", owner, m_owner);
            chk("ram_we", ram_we, act && cyc == g && g_we);
            chk("ram_addr", ram_addr, m_addr);
            chk("ram_din", ram_din, m_din);
            chk("cpu_ack", cpu_ack, act && cyc == g + 1 && !m_owner);
            chk("dbg_ack", dbg_ack, act && cyc == g + 1 && m_owner);
            chk("cpu_dout", cpu_dout, m_cdout);
            chk("dbg_dout", dbg_dout, m_ddout);
        end
    end

    // Requester drivers: hold an op until ack, drop req in the ack cycle
    op_t cq[$], dq[$];
    int ack_log[$], lat_log[$];
    int ncnt = 0, c_t0 = 0, d_t0 = 0;

    task automatic step();
        @(negedge clk);
        ncnt++;
        if (cpu_req && cpu_ack) begin
            cpu_req = 1'b0; ack_log.push_back(0); lat_log.push_back(ncnt - c_t0);
            void'(cq.pop_front());
        end else if (!cpu_req && cq.size() > 0) begin
            cpu_req = 1'b1; {cpu_we, cpu_addr, cpu_din} = cq[0]; c_t0 = ncnt;
        end
        if (dbg_req && dbg_ack) begin
            dbg_req = 1'b0; ack_log.push_back(1); lat_log.push_back(ncnt - d_t0);
            void'(dq.pop_front());
        end else if (!dbg_req && dq.size() > 0) begin
            dbg_req = 1'b1; {dbg_we, dbg_addr, dbg_din} = dq[0]; d_t0 = ncnt;
        end
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        while ((cq.size() > 0 || dq.size() > 0 || cpu_req || dbg_req) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_in_budget", n < maxc, 1'b1);
        repeat (3) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0;
        cq.delete(); dq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_seq(input string n, input int e[$]);
        chk({n, "_len"}, ack_log.size(), e.size());
        for (int i = 0; i < e.size() && i < ack_log.size(); i++) chk(n, ack_log[i], e[i]);
    endtask

    task automatic chk_reset_vals(input string n);
        chk({n, "_ram_we"}, ram_we, 0);
        chk({n, "_ram_addr"}, ram_addr, 0);
        chk({n, "_ram_din"}, ram_din, 0);
        chk({n, "_acks"}, {cpu_ack, dbg_ack}, 0);
        chk({n, "_douts"}, {cpu_dout, dbg_dout}, 0);
        chk({n, "_owner"}, owner, 1);
        chk({n, "_busy"}, busy, 0);
    endtask

    int e_seq[$];
    int mx;

    initial begin
        #1 reset = 1'b1;
        #1 chk_reset_vals("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // CPU write then read of 0x0012
        cq.push_back('{1'b1, 16'h0012, 16'hBEEF});
        cq.push_back('{1'b0, 16'h0012, 16'h0000});
        run_idle(40);
        chk("t1_cpu_dout", cpu_dout, 16'hBEEF);
        e_seq = '{0, 0};
        chk_seq("t1_ack_order", e_seq);
        chk("t1_lat0", lat_log[0], 2);
        chk("t1_lat1", lat_log[1], 2);

        // Tie straight after reset
        do_reset();
        ack_log.delete(); lat_log.delete();
        cq.push_back('{1'b1, 16'h0030, 16'h1111});
        dq.push_back('{1'b1, 16'h0031, 16'h2222});
        run_idle(40);
`ifdef MEM_ARB_DBG_PRIORITY_EN
        e_seq = '{1, 0};
`else
        e_seq = '{0, 1};
`endif
        chk_seq("t2_tie_order", e_seq);

        // Both sides requesting back to back for 8 accesses
        ack_log.delete(); lat_log.delete();
        cq.push_back('{1'b1, 16'h0040, 16'hA001});
        cq.push_back('{1'b0, 16'h0040, 16'h0000});
        cq.push_back('{1'b1, 16'h0041, 16'hA002});
        cq.push_back('{1'b0, 16'h0041, 16'h0000});
        dq.push_back('{1'b1, 16'h0050, 16'hB001});
        dq.push_back('{1'b0, 16'h0050, 16'h0000});
        dq.push_back('{1'b1, 16'h0051, 16'hB002});
        dq.push_back('{1'b0, 16'h0030, 16'h0000});
        run_idle(100);
`ifdef MEM_ARB_DBG_PRIORITY_EN
        e_seq = '{1, 1, 1, 1, 0, 0, 0, 0};
`else
        e_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
        mx = 0;
        foreach (lat_log[i]) if (lat_log[i] > mx) mx = lat_log[i];
        chk("t3_max_wait", mx, 5);
`endif
        chk_seq("t3_stream_order", e_seq);
        chk("t3_cpu_dout", cpu_dout, 16'hA002);
        chk("t3_dbg_dout", dbg_dout, 16'h1111);

        // Address truncation: 0x01FF aliases word 0xFF
        cq.push_back('{1'b1, 16'h00FF, 16'h1234});
        run_idle(40);
        dq.push_back('{1'b0, 16'h01FF, 16'h0000});
        run_idle(40);
        chk("t4_dbg_dout_trunc", dbg_dout, 16'h1234);

        // Reset in the ACC cycle of a write aborts it
        cq.push_back('{1'b1, 16'h0077, 16'h5555});
        run_idle(40);
        cq.push_back('{1'b1, 16'h0077, 16'hDEAD});
        step();
        step();
        chk("t5_acc_we", ram_we, 1);
        #2 reset = 1'b1; cpu_req = 1'b0; cq.delete();
        #1 chk_reset_vals("t5_abort");
        @(negedge clk);
        chk_reset_vals("t5_hold");
        @(negedge clk);
        reset = 1'b0;
        cq.push_back('{1'b0, 16'h0077, 16'h0000});
        run_idle(40);
        chk("t5_old_data", cpu_dout, 16'h5555);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port synchronous RAM between the RISC processor and the debug memory-dump/load port. Replaces the static `dump_mem` address mux in the lab top level with a req/ack handshake, so the CPU and the debug path can both be live without corrupting each other's accesses. Sits between the requesters and the `ram` instance and drives the RAM's `we/addr/din` and captures its `dout`.

## Interface

**Parameters**
- `ADDR_W`, default 8: RAM address width. Requester addresses are truncated to the low `ADDR_W` bits.
- `DATA_W`, default 16: data width.

**Ports**
- `clk` in 1: system clock. Same clock as the RAM.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU access request.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in 16: CPU address.
- `cpu_din` in `DATA_W`: CPU write data.
- `cpu_ack` out 1: one-cycle completion pulse to the CPU.
- `cpu_dout` out `DATA_W`: CPU read data.
- `dbg_req`, `dbg_we`, `dbg_addr[15:0]`, `dbg_din`, `dbg_ack`, `dbg_dout`: same meaning as the CPU set, for the debug port.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out `ADDR_W`: RAM address.
- `ram_din` out `DATA_W`: RAM write data.
- `ram_dout` in `DATA_W`: RAM read data. Valid the cycle after the address is presented.
- `owner` out 1: 0 = CPU, 1 = debug. Identifies the last/current grantee and drives a status LED.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation

**FSM states:** IDLE, ACC, DONE.

**IDLE**
- Samples `cpu_req` and `dbg_req`.
- If any request is present, latches the winner into `owner` and goes to ACC.
- Latches the winner's `we`, `addr[ADDR_W-1:0]` and `din` into the `ram_*` output registers.
- `ram_we` is 1 in ACC only, and only for a write.

**ACC**
- RAM performs the access at the end of this cycle. Always goes to DONE.

**DONE**
- Pulses the owner's `ack` for one cycle.
- For a read, `*_dout` for the owner is loaded from `ram_dout` on the DONE→IDLE edge and held until that owner's next read.
- For a write, `*_dout` is unchanged.
- Always goes to IDLE.

**Arbitration (default):** round-robin between the two requesters.
- If both request in IDLE, grant the requester that was not granted last.
- If only one requests, grant it.
- The last-grant register resets to debug, so the CPU wins the first tie.

**Handshake rules**
- A requester holds `req`, `we`, `addr` and `din` stable from assertion until `ack`.
- A requester drops `req` by the edge that ends the `ack` cycle.
- A `req` still high in the IDLE cycle after `ack` is a new request.

**Boundary conditions**
- The non-granted requester keeps waiting. Its request is never dropped or lost.
- Address bits `[15:ADDR_W]` are ignored. Address `0x01FF` accesses RAM word `0xFF`.
- A request arriving while `busy` waits for the next IDLE.
- Reset mid-access: the FSM asynchronously returns to IDLE and an in-flight write is aborted (`ram_we` drops immediately). No `ack` is issued.

## Timing
- Reset values:
  - state = IDLE
  - `cpu_ack` = `dbg_ack` = 0
  - `ram_we` = 0
  - `ram_addr` = 0
  - `ram_din` = 0
  - `cpu_dout` = `dbg_dout` = 0
  - `owner` = 1
  - `busy` = 0
- Latency: `req` sampled high at edge k gives ACC during cycle k..k+1 and `ack` high during cycle k+1..k+2. The ack pulse arrives 2 cycles after sampling.
- Throughput: one access per 3 cycles.
- All outputs are registered. No combinational path from `*_req` to any output.

## Configuration
- `MEM_ARB_DBG_PRIORITY_EN`
  - Defined: fixed priority, debug always wins ties. A continuously requesting debug port may starve the CPU; this is intended for halt-and-dump sessions.
  - Undefined: round-robin as described under Operation.

## Structure
- Package `mem_arb_pkg`:
  - state encoding constants: IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2
  - requester IDs: REQ_CPU = 1'b0, REQ_DBG = 1'b1
- Sub-module `mem_arb_pick`: combinational winner selection from `cpu_req`, `dbg_req` and last-grant. Contains the `MEM_ARB_DBG_PRIORITY_EN` switch.
- RAM instance stays outside the block.

## Test plan
- CPU write 0xBEEF to `addr` 0x0012, then read 0x0012 → `cpu_ack` pulses 2 cycles after each request is sampled; `cpu_dout` = 0xBEEF; `dbg_ack` stays 0.
- CPU and debug both request in the same IDLE cycle after reset → CPU granted first (`owner` = 0), debug next (`owner` = 1); with the macro defined, debug is granted first.
- Both requesters hold requests continuously for 8 accesses → grants alternate CPU/debug; neither side waits more than one access.
- Debug read of `addr` 0x01FF after CPU writes 0x1234 to 0x00FF → `dbg_dout` = 0x1234 (truncation).
- Assert `reset` during ACC of a write → `ram_we` falls immediately; no `ack`; all outputs at reset values; a later read of that address returns the old data.
